// File: rtl/count_write_loader.sv
// Count-register write loader: assembles CPU count bytes into a 2*BUS_W count per the RW mode.
// Optional BCD nibble clamping and sticky error flag when COUNT_BCD_CHECK_EN is defined.
module count_write_loader #(
  parameter int BUS_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cw_write,
  input  logic [1:0]         cw_rw,
  input  logic               cw_bcd,
  input  logic               wr_strobe,
  input  logic [BUS_W-1:0]   data_in,
  output logic [2*BUS_W-1:0] new_count,
  output logic               load,
  output logic               count_hold,
  output logic               null_count,
  output logic               bcd_err
);

  typedef enum logic [1:0] {
    UNPROG       = 2'd0,
    EXPECT_FIRST = 2'd1,
    EXPECT_MSB   = 2'd2
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [1:0]           r_rw, w_rw_nxt;
  logic [BUS_W-1:0]     r_lsb, w_lsb_nxt;
  logic [2*BUS_W-1:0]   r_count, w_count_nxt;
  logic                 r_load, w_load_nxt;
  logic                 r_hold, w_hold_nxt;
  logic                 r_null, w_null_nxt;
  logic                 r_err, w_err_nxt;
  logic [BUS_W-1:0]     w_byte;
  logic                 w_bad;

`ifdef COUNT_BCD_CHECK_EN
  logic                 r_bcd, w_bcd_nxt;

  function automatic logic [BUS_W-1:0] bcd_clamp(input logic [BUS_W-1:0] b);
    logic [BUS_W-1:0] r;
    r = b;
    for (int i = 0; i < BUS_W / 4; i++)
      if (b[i*4 +: 4] > 4'd9) r[i*4 +: 4] = 4'd9;
    return r;
  endfunction

  function automatic logic bcd_bad(input logic [BUS_W-1:0] b);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < BUS_W / 4; i++)
      if (b[i*4 +: 4] > 4'd9) bad = 1'b1;
    return bad;
  endfunction

  assign w_byte = r_bcd ? bcd_clamp(data_in) : data_in;
  assign w_bad  = r_bcd & bcd_bad(data_in);
`else
  assign w_byte = data_in;
  assign w_bad  = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_rw_nxt    = r_rw;
    w_lsb_nxt   = r_lsb;
    w_count_nxt = r_count;
    w_load_nxt  = 1'b0;
    w_hold_nxt  = r_hold;
    w_null_nxt  = r_null;
    w_err_nxt   = r_err;
`ifdef COUNT_BCD_CHECK_EN
    w_bcd_nxt   = r_bcd;
`endif
    // A real control word wins over a coincident data byte; a latch command (RW=00) is transparent.
    if (cw_write && cw_rw != 2'b00) begin
      w_rw_nxt    = cw_rw;
      w_null_nxt  = 1'b1;
      w_hold_nxt  = 1'b0;
      w_err_nxt   = 1'b0;
      w_state_nxt = EXPECT_FIRST;
`ifdef COUNT_BCD_CHECK_EN
      w_bcd_nxt   = cw_bcd;
`endif
    end else if (wr_strobe) begin
      case (r_state)
        EXPECT_FIRST: begin
          case (r_rw)
            2'b01: begin
              w_count_nxt = {{BUS_W{1'b0}}, w_byte};
              w_load_nxt  = 1'b1;
              w_null_nxt  = 1'b0;
              w_err_nxt   = r_err | w_bad;
            end
            2'b10: begin
              w_count_nxt = {w_byte, {BUS_W{1'b0}}};
              w_load_nxt  = 1'b1;
              w_null_nxt  = 1'b0;
              w_err_nxt   = r_err | w_bad;
            end
            2'b11: begin
              w_lsb_nxt   = w_byte;
              w_hold_nxt  = 1'b1;
              w_err_nxt   = r_err | w_bad;
              w_state_nxt = EXPECT_MSB;
            end
            default: ;
          endcase
        end
        EXPECT_MSB: begin
          w_count_nxt = {w_byte, r_lsb};
          w_hold_nxt  = 1'b0;
          w_load_nxt  = 1'b1;
          w_null_nxt  = 1'b0;
          w_err_nxt   = r_err | w_bad;
          w_state_nxt = EXPECT_FIRST;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= UNPROG;
      r_rw    <= 2'b00;
      r_lsb   <= '0;
      r_count <= '0;
      r_load  <= 1'b0;
      r_hold  <= 1'b0;
      r_null  <= 1'b0;
      r_err   <= 1'b0;
`ifdef COUNT_BCD_CHECK_EN
      r_bcd   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_rw    <= w_rw_nxt;
      r_lsb   <= w_lsb_nxt;
      r_count <= w_count_nxt;
      r_load  <= w_load_nxt;
      r_hold  <= w_hold_nxt;
      r_null  <= w_null_nxt;
      r_err   <= w_err_nxt;
`ifdef COUNT_BCD_CHECK_EN
      r_bcd   <= w_bcd_nxt;
`endif
    end
  end

  assign new_count  = r_count;
  assign load       = r_load;
  assign count_hold = r_hold;
  assign null_count = r_null;
  assign bcd_err    = r_err;

endmodule

// File: tb/tb_count_write_loader.sv
// Self-checking bench for count_write_loader; expected counts are queued at stimulus time
// and popped by a monitor whenever load pulses.
module tb_count_write_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        cw_write;
  logic [1:0]  cw_rw;
  logic        cw_bcd;
  logic        wr_strobe;
  logic [7:0]  data_in;
  logic [15:0] new_count;
  logic        load;
  logic        count_hold;
  logic        null_count;
  logic        bcd_err;

  int checks   = 0;
  int failures = 0;
  logic [15:0] exp_q[$];

  count_write_loader #(.BUS_W(8)) dut (
    .clk(clk), .rst(rst), .cw_write(cw_write), .cw_rw(cw_rw), .cw_bcd(cw_bcd),
    .wr_strobe(wr_strobe), .data_in(data_in), .new_count(new_count), .load(load),
    .count_hold(count_hold), .null_count(null_count), .bcd_err(bcd_err)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: every load pulse must match the oldest queued count.
  always @(negedge clk) begin
    if (load === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_load new_count=%h expected no load", new_count);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (new_count !== e) begin
          failures++;
          $display("FAIL load_count actual=%h expected=%h", new_count, e);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cw(input logic [1:0] rw, input logic bcd);
    cw_write = 1'b1; cw_rw = rw; cw_bcd = bcd;
    cyc();
    cw_write = 1'b0; cw_rw = 2'b00; cw_bcd = 1'b0;
  endtask

  task automatic do_wr(input logic [7:0] d);
    wr_strobe = 1'b1; data_in = d;
    cyc();
    wr_strobe = 1'b0; data_in = 8'h00;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    checks++;
    if ({new_count, load, count_hold, null_count, bcd_err} !== 20'h0_0000) begin
      failures++;
      $display("FAIL reset_outputs count=%h load=%b hold=%b null=%b err=%b expected all zero",
               new_count, load, count_hold, null_count, bcd_err);
    end
    do_wr(8'h55);
    checks++;
    if (load !== 1'b0 || new_count !== 16'h0000) begin
      failures++;
      $display("FAIL unprog_write load=%b count=%h expected 0/0000", load, new_count);
    end
  endtask

  task automatic test_rw11();
    do_cw(2'b11, 1'b0);
    checks++;
    if (null_count !== 1'b1 || count_hold !== 1'b0) begin
      failures++;
      $display("FAIL rw11_cw null=%b hold=%b expected 1/0", null_count, count_hold);
    end
    exp_q.push_back(16'h1234);
    do_wr(8'h34);
    checks++;
    if (count_hold !== 1'b1 || load !== 1'b0 || null_count !== 1'b1) begin
      failures++;
      $display("FAIL rw11_lsb hold=%b load=%b null=%b expected 1/0/1", count_hold, load, null_count);
    end
    do_wr(8'h12);
    checks++;
    if (load !== 1'b1 || count_hold !== 1'b0 || null_count !== 1'b0) begin
      failures++;
      $display("FAIL rw11_msb load=%b hold=%b null=%b expected 1/0/0", load, count_hold, null_count);
    end
    cyc();
    checks++;
    if (load !== 1'b0 || new_count !== 16'h1234 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL rw11_after load=%b count=%h pending=%0d expected 0/1234/0",
               load, new_count, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    do_cw(2'b01, 1'b0);
    exp_q.push_back(16'h0003);
    do_wr(8'h03);
    checks++;
    if (load !== 1'b1) begin
      failures++;
      $display("FAIL b2b_first load=%b expected 1", load);
    end
    exp_q.push_back(16'h0004);
    do_wr(8'h04);
    checks++;
    if (load !== 1'b1) begin
      failures++;
      $display("FAIL b2b_second load=%b expected 1", load);
    end
    cyc();
    checks++;
    if (load !== 1'b0 || new_count !== 16'h0004 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL b2b_after load=%b count=%h pending=%0d expected 0/0004/0",
               load, new_count, exp_q.size());
    end
  endtask

  task automatic test_rw10_latch();
    do_cw(2'b10, 1'b0);
    exp_q.push_back(16'hA500);
    do_wr(8'hA5);
    cyc();
    do_cw(2'b00, 1'b0);
    cyc();
    checks++;
    if (new_count !== 16'hA500 || load !== 1'b0 || count_hold !== 1'b0 || null_count !== 1'b0) begin
      failures++;
      $display("FAIL latch_cmd count=%h load=%b hold=%b null=%b expected A500/0/0/0",
               new_count, load, count_hold, null_count);
    end
    exp_q.push_back(16'h5A00);
    do_wr(8'h5A);
    cyc();
    checks++;
    if (new_count !== 16'h5A00 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL latch_mode_kept count=%h pending=%0d expected 5A00/0", new_count, exp_q.size());
    end
  endtask

  task automatic test_collision();
    do_cw(2'b11, 1'b0);
    do_wr(8'h34);
    cw_write = 1'b1; cw_rw = 2'b11; wr_strobe = 1'b1; data_in = 8'h77;
    cyc();
    cw_write = 1'b0; cw_rw = 2'b00; wr_strobe = 1'b0; data_in = 8'h00;
    checks++;
    if (load !== 1'b0 || count_hold !== 1'b0 || null_count !== 1'b1) begin
      failures++;
      $display("FAIL collision load=%b hold=%b null=%b expected 0/0/1", load, count_hold, null_count);
    end
    do_wr(8'h78);
    checks++;
    if (count_hold !== 1'b1 || load !== 1'b0) begin
      failures++;
      $display("FAIL collision_first hold=%b load=%b expected 1/0", count_hold, load);
    end
    exp_q.push_back(16'h5678);
    do_wr(8'h56);
    cyc();
    checks++;
    if (new_count !== 16'h5678 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL collision_count count=%h pending=%0d expected 5678/0", new_count, exp_q.size());
    end
  endtask

  task automatic test_rst_abandon();
    do_cw(2'b11, 1'b0);
    do_wr(8'h34);
    rst = 1'b1; cw_write = 1'b1; cw_rw = 2'b01;
    cyc();
    rst = 1'b0; cw_write = 1'b0; cw_rw = 2'b00;
    do_wr(8'h12);
    checks++;
    if ({new_count, load, count_hold, null_count, bcd_err} !== 20'h0_0000) begin
      failures++;
      $display("FAIL rst_abandon count=%h load=%b hold=%b null=%b err=%b expected all zero",
               new_count, load, count_hold, null_count, bcd_err);
    end
  endtask

  task automatic test_bcd_and_zero();
    logic [15:0] exp_c;
    logic        exp_e;
`ifdef COUNT_BCD_CHECK_EN
    exp_c = 16'h0039; exp_e = 1'b1;
`else
    exp_c = 16'h003C; exp_e = 1'b0;
`endif
    do_cw(2'b01, 1'b1);
    exp_q.push_back(exp_c);
    do_wr(8'h3C);
    cyc();
    checks++;
    if (new_count !== exp_c || bcd_err !== exp_e) begin
      failures++;
      $display("FAIL bcd_write count=%h err=%b expected %h/%b", new_count, bcd_err, exp_c, exp_e);
    end
    do_cw(2'b01, 1'b0);
    checks++;
    if (bcd_err !== 1'b0) begin
      failures++;
      $display("FAIL bcd_err_clear err=%b expected 0", bcd_err);
    end
    exp_q.push_back(16'h003C);
    do_wr(8'h3C);
    exp_q.push_back(16'h0000);
    do_wr(8'h00);
    cyc();
    checks++;
    if (new_count !== 16'h0000 || bcd_err !== 1'b0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL binary_zero count=%h err=%b pending=%0d expected 0000/0/0",
               new_count, bcd_err, exp_q.size());
    end
  endtask

  initial begin
    rst = 1'b1; cw_write = 1'b0; cw_rw = 2'b00; cw_bcd = 1'b0;
    wr_strobe = 1'b0; data_in = 8'h00;
    test_reset();
    test_rw11();
    test_back_to_back();
    test_rw10_latch();
    test_collision();
    test_rst_abandon();
    test_bcd_and_zero();
    cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/count_write_loader.md
COUNT_WRITE_LOADER -- requirements
Module: count_write_loader

Interface
REQ-001 SHALL have parameter BUS_W, default 8: CPU data byte width; count width is 2*BUS_W (16).
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port cw_write, input, 1: one-cycle strobe; a control word addressed to this counter is valid.
REQ-005 SHALL have port cw_rw, input, 2: RW field of that control word (00 latch cmd, 01 LSB only, 10 MSB only, 11 LSB then MSB).
REQ-006 SHALL have port cw_bcd, input, 1: BCD bit of that control word.
REQ-007 SHALL have port wr_strobe, input, 1: one-cycle strobe; CPU writes a count byte.
REQ-008 SHALL have port data_in, input, 8: count byte, sampled when wr_strobe=1.
REQ-009 SHALL have port new_count, output, 16: assembled count for the counter.
REQ-010 SHALL have port load, output, 1: one-cycle pulse; counter takes new_count.
REQ-011 SHALL have port count_hold, output, 1: high between LSB and MSB writes in RW=11.
REQ-012 SHALL have port null_count, output, 1: high from control word write until the next load pulse.
REQ-013 SHALL have port bcd_err, output, 1: sticky invalid-BCD flag (Configuration only; else tied 0).

Function
REQ-014 SHALL hold a registered RW mode; cw_write with cw_rw!=00 SHALL update it and bcd mode, set null_count, clear count_hold, and enter state EXPECT_FIRST.
REQ-015 SHALL ignore cw_write with cw_rw=00 (latch command): no change to mode, state, null_count or outputs.
REQ-016 SHALL use states UNPROG, EXPECT_FIRST, EXPECT_MSB; UNPROG after reset; wr_strobe in UNPROG ignored.
REQ-017 SHALL, in EXPECT_FIRST with RW=01, on wr_strobe set new_count={8'h00,data_in} and pulse load next cycle; state stays EXPECT_FIRST.
REQ-018 SHALL, in EXPECT_FIRST with RW=10, on wr_strobe set new_count={data_in,8'h00} and pulse load next cycle; state stays EXPECT_FIRST.
REQ-019 SHALL, in EXPECT_FIRST with RW=11, on wr_strobe store data_in as LSB, raise count_hold, go EXPECT_MSB, no load.
REQ-020 SHALL, in EXPECT_MSB, on wr_strobe set new_count={data_in,stored LSB}, clear count_hold, pulse load next cycle, return to EXPECT_FIRST.
REQ-021 SHALL register new_count in the same edge that sets load and hold it stable until the next completed write.
REQ-022 SHALL keep load high exactly one cycle per completed write; back-to-back writes yield back-to-back pulses.
REQ-023 SHALL clear null_count in the cycle load is high.
REQ-024 SHALL give cw_write priority when cw_write and wr_strobe coincide; that data byte is discarded.
REQ-025 SHALL discard a pending LSB on cw_write received in EXPECT_MSB.
REQ-026 SHALL pass count value 0 unchanged (terminal-count interpretation belongs to the counter).

Reset
REQ-027 SHALL, on rst=1 at a clock edge, set new_count=16'h0000, load=0, count_hold=0, null_count=0, bcd_err=0, RW=00, state UNPROG.
REQ-028 SHALL give rst priority over cw_write and wr_strobe; a write in progress is abandoned with no load pulse.

Configuration
REQ-029 SHALL, with macro COUNT_BCD_CHECK_EN defined and bcd mode=1, clamp any written nibble >9 to 9 in new_count and set bcd_err until next cw_write or rst.
REQ-030 SHALL, without COUNT_BCD_CHECK_EN, pass nibbles unchanged and tie bcd_err to 0.

Verification
REQ-031 SHALL cover: rst, cw_write RW=11, wr 8'h34 then 8'h12 -> count_hold high between, one load pulse, new_count=16'h1234, null_count clears with load.
REQ-032 SHALL cover: cw_write RW=01, wr 8'h03 -> load one cycle later, new_count=16'h0003; second wr 8'h04 -> second pulse, 16'h0004.
REQ-033 SHALL cover: cw_write RW=10, wr 8'hA5 -> new_count=16'hA500; then cw_write RW=00 -> no change to any output.
REQ-034 SHALL cover: RW=11, wr 8'h34, then cw_write RW=11 + wr_strobe 8'h77 same cycle -> no load, state EXPECT_FIRST, 8'h34 discarded.
REQ-035 SHALL cover: RW=11, wr 8'h34, rst pulse, wr 8'h12 -> no load, all outputs at reset values, write ignored (UNPROG).
REQ-036 SHALL cover: COUNT_BCD_CHECK_EN defined, bcd=1, RW=01, wr 8'h3C -> new_count=16'h0039, bcd_err=1; undefined -> 16'h003C, bcd_err=0.
